// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared defaults and index-width helper for the bus arbiter/mux
package bus_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int N_SRC_DEF  = 24;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_picker.sv
// rtl/prio_picker.sv - combinational first-set search from a start index, wrapping N-1 -> 0
module prio_picker #(
  parameter int N  = 24,
  parameter int IW = 5
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// rtl/bus_arbiter_mux.sv - registered N-source bus arbiter and data mux with lock
// Define BUS_RR_ARB_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module bus_arbiter_mux
  import bus_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_SRC  = N_SRC_DEF
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic [N_SRC-1:0]          req,
  input  logic [N_SRC*DATA_W-1:0]   bus_in,
  input  logic                      hold,
  output logic [DATA_W-1:0]         bus_out,
  output logic [N_SRC-1:0]          grant,
  output logic [idx_w(N_SRC)-1:0]   src_idx,
  output logic                      valid,
  output logic                      conflict
);

  localparam int IW = idx_w(N_SRC);

  logic [DATA_W-1:0] w_words [N_SRC];
  logic [N_SRC-1:0]  w_pick_oh;
  logic [IW-1:0]     w_pick_idx;
  logic              w_pick_any;
  logic [IW-1:0]     w_start;
  logic              w_locked;
  logic [IW-1:0]     w_sel;
  logic              w_conflict;

  logic [DATA_W-1:0] r_bus;
  logic [N_SRC-1:0]  r_grant;
  logic [IW-1:0]     r_idx;
  logic              r_valid;
  logic              r_conflict;

  for (genvar i = 0; i < N_SRC; i++) begin : g_words
    assign w_words[i] = bus_in[i*DATA_W +: DATA_W];
  end

`ifdef BUS_RR_ARB_EN
  logic [IW-1:0] r_ptr;
  assign w_start = r_ptr;

  // Pointer only advances on a fresh grant; idle and locked cycles leave it alone.
  always_ff @(posedge clock) begin
    if (!clear) begin
      r_ptr <= '0;
    end else if (!w_locked && w_pick_any) begin
      r_ptr <= (w_pick_idx == IW'(N_SRC - 1)) ? '0 : w_pick_idx + IW'(1);
    end
  end
`else
  assign w_start = '0;
`endif

  prio_picker #(
    .N  (N_SRC),
    .IW (IW)
  ) u_picker (
    .req    (req),
    .start  (w_start),
    .onehot (w_pick_oh),
    .idx    (w_pick_idx),
    .found  (w_pick_any)
  );

  // Lock holds only while the owner still requests; otherwise arbitrate this cycle.
  assign w_locked   = hold & r_valid & req[r_idx];
  assign w_sel      = w_locked ? r_idx : w_pick_idx;
  assign w_conflict = |(req & (req - N_SRC'(1)));

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_bus      <= '0;
      r_grant    <= '0;
      r_idx      <= '0;
      r_valid    <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_conflict;
      if (w_locked) begin
        r_bus <= w_words[w_sel];
      end else if (w_pick_any) begin
        r_grant <= w_pick_oh;
        r_idx   <= w_pick_idx;
        r_valid <= 1'b1;
        r_bus   <= w_words[w_sel];
      end else begin
        r_grant <= '0;
        r_idx   <= '0;
        r_valid <= 1'b0;
      end
    end
  end

  assign bus_out  = r_bus;
  assign grant    = r_grant;
  assign src_idx  = r_idx;
  assign valid    = r_valid;
  assign conflict = r_conflict;

endmodule

// File: doc/bus_arbiter_mux.md
BUS_ARBITER_MUX -- requirements
Module: bus_arbiter_mux

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning bus word width in bits.
REQ-002 The block SHALL have parameter N_SRC, default 24, meaning number of bus sources (legal range 2..64).
REQ-003 Port clock, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port clear, input, 1, is reset: synchronous, active-low.
REQ-005 Port req, input, N_SRC, carries per-source drive requests (bit i = source i wants the bus).
REQ-006 Port bus_in, input, N_SRC*DATA_W, packs source data; source i occupies bits [i*DATA_W +: DATA_W].
REQ-007 Port hold, input, 1, is the bus lock: while high, the current owner keeps the bus.
REQ-008 Port bus_out, output, DATA_W, is the registered bus value.
REQ-009 Port grant, output, N_SRC, is the registered one-hot owner; all zeros when idle.
REQ-010 Port src_idx, output, $clog2(N_SRC), is the binary index of the current owner; 0 when idle.
REQ-011 Port valid, output, 1, is high when grant is non-zero.
REQ-012 Port conflict, output, 1, flags that two or more requests were pending in the previous cycle.

Function
REQ-013 Latency: req and bus_in are sampled at edge k; grant, src_idx, valid and bus_out reflect that sample after edge k, a 1-cycle latency.
REQ-014 The owner's data SHALL be registered: bus_out <= bus_in[winner] at each edge while valid is high.
REQ-015 Idle (req == 0): grant = 0, src_idx = 0, valid = 0, and bus_out holds its last value.
REQ-016 Single request: that source wins, regardless of arbitration mode.
REQ-017 Lock: hold = 1 with the current owner's req still high keeps grant unchanged, and bus_out continues tracking that owner's live data.
REQ-018 Lock release: hold = 1 with the owner's req dropped rearbitrates normally in the same cycle.
REQ-019 hold = 1 while idle has no effect.
REQ-020 Multiple requests without lock are resolved by the arbitration mode (REQ-025/REQ-026).
REQ-021 conflict is registered: conflict = 1 after edge k iff popcount(req) >= 2 at edge k; it is not sticky.
REQ-022 grant SHALL never have more than one bit set.
REQ-023 Bits of bus_in belonging to non-requesting sources SHALL never reach bus_out.

Reset
REQ-024 With clear = 0 at an edge: bus_out = 0, grant = 0, src_idx = 0, valid = 0, conflict = 0, and the round-robin pointer = 0. Reset overrides req and hold, including mid-lock.

Configuration
REQ-025 With macro BUS_RR_ARB_EN defined, arbitration SHALL be round-robin:
- search starts at pointer, ascending, wrapping N_SRC-1 -> 0;
- after each grant, pointer <= winner + 1 mod N_SRC;
- pointer is unchanged when idle or locked.
REQ-026 Without BUS_RR_ARB_EN, arbitration SHALL be fixed priority, lowest index wins; no pointer register exists.

Structure
REQ-027 The shared package bus_pkg SHALL hold the DATA_W/N_SRC defaults and the index-width localparam function.
REQ-028 The winner selection SHALL be a sub-module, prio_picker: combinational, inputs req and start index, outputs a one-hot and binary winner. Fixed-priority mode ties the start index to 0.

Verification (N_SRC=24, DATA_W=32)
REQ-029 Reset: clear=0 with req=all-ones -> after the edge, all outputs 0; the following edge with clear=1 grants source 0.
REQ-030 Single source: req[0]=1, bus_in[0]=23 -> one edge later bus_out=23, grant=24'h000001, src_idx=0, valid=1; req=0 at the next edge -> valid=0, bus_out stays 23.
REQ-031 Conflict, RR mode: req bits 12 and 20 held high with data 4 and 99 -> successive owners 12, 20, 12; bus_out 4, 99, 4; conflict=1 each cycle. Fixed mode under the same stimulus -> owner 12 every cycle.
REQ-032 Wrap: RR pointer at 23, req bits 23 and 1 -> owner 23, then 1, then 23.
REQ-033 Lock: owner 5 (data 7), hold=1, req bit 2 also raised, bus_in[5] changed to 8 -> grant stays bit 5, bus_out=8; drop req[5] -> owner becomes 2 on that edge.
REQ-034 Mid-lock reset: hold=1, owner 9, clear=0 for one edge -> all outputs 0; RR pointer restarts at 0.
